// File: rtl/mp_pkg.sv
// Shared microprocessor definitions: bus widths, the stop-bit position and the
// fetch state encoding used by the fetch unit, decode and instruction memory.
package mp_pkg;

   localparam int unsigned ADDR_W   = 7;   // 128-entry instruction memory
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned STOP_BIT = 0;   // LSB=1 marks the last instruction
   localparam int unsigned CNT_W    = 16;  // width of the optional fetch counter

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: read-side master of the 128x16 instruction memory.
// Owns the PC, registers each returned word toward decode with a valid flag,
// and handles stall, branch redirect and the stop bit.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               pulse: begin fetching at START_ADDR from IDLE or HALT
//   stall               decode not ready: hold PC and output registers
//   branch_en/_addr     redirect request from execute (wins over stall)
//   imem_addr, imem_rd  memory address (= pc) and read enable
//   imem_rdata          combinational read data, valid in the same cycle
//   instr, instr_valid  registered instruction to decode
//   pc                  current fetch address
//   halted              stop bit fetched, fetch stopped
//   fetch_count         (FETCH_PERF_CNT_EN only) saturating count of accepted fetches
//
// Optional feature macro: FETCH_PERF_CNT_EN
module instruction_fetch_unit
   import mp_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_rd,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   fetch_count
`endif
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               halted_q, halted_d;
   logic               rd_q, rd_d;
   logic               fetch_new;    // a fresh word is being accepted this edge
   logic               restart;      // start honoured this edge

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= START_ADDR;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         rd_q     <= rd_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      fetch_new = 1'b0;
      restart   = 1'b0;

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               restart = 1'b1;
               pc_d    = START_ADDR;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (branch_en) begin
               // word read at the old pc is discarded; one bubble to decode
               pc_d    = branch_addr;
               valid_d = 1'b0;
            end else if (!stall) begin
               fetch_new = 1'b1;
               instr_d   = imem_rdata;
               valid_d   = 1'b1;
               if (imem_rdata[STOP_BIT]) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end
         end
         HALT: begin
            if (start) begin
               restart  = 1'b1;
               pc_d     = START_ADDR;
               halted_d = 1'b0;
               valid_d  = 1'b0;
               state_d  = FETCH;
            end else if (!stall) begin
               // last word stays valid only until decode accepts it
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_d = (state_d == FETCH);
   end

   assign imem_addr   = pc_q;
   assign imem_rd     = rd_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of accepted (non-discarded) fetches, cleared on start
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (fetch_new && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_count = cnt_q;
`else
   logic unused_flags;
   assign unused_flags = fetch_new ^ restart;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;
   import mp_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               stall = 1'b0;
   logic               branch_en = 1'b0;
   logic [ADDR_W-1:0]  branch_addr = '0;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_rd;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [ADDR_W-1:0]  pc;
   logic               halted;
`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0]   fetch_count;
`endif

   logic [INSTR_W-1:0] mem [128];

   int tests = 0;
   int fails = 0;

   // Behavioural model: running / halted flags plus expected visible outputs
   bit          m_running, m_halted_st;
   int          m_pc, m_cnt;
   logic [15:0] m_instr;
   bit          m_valid;

   instruction_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_running = 0; m_halted_st = 0; m_pc = 0; m_instr = '0; m_valid = 0; m_cnt = 0;
   endtask

   // One clock edge of the model, using the memory word at the model's pc
   task automatic model_edge(input bit s, input bit st, input bit b, input int ba);
      logic [15:0] word;
      word = mem[m_pc];
      if (!m_running && !m_halted_st) begin
         if (s) begin m_pc = 0; m_running = 1; m_cnt = 0; end
      end else if (m_running) begin
         if (b) begin
            m_pc = ba; m_valid = 0;
         end else if (!st) begin
            m_instr = word; m_valid = 1;
            if (m_cnt < 65535) m_cnt++;
            if (word[0]) begin m_running = 0; m_halted_st = 1; end
            else m_pc = (m_pc + 1) % 128;
         end
      end else begin
         if (s) begin
            m_pc = 0; m_halted_st = 0; m_running = 1; m_valid = 0; m_cnt = 0;
         end else if (!st) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc"},     32'(pc),          32'(m_pc));
      chk({tag, ".instr"},  32'(instr),       32'(m_instr));
      chk({tag, ".valid"},  32'(instr_valid), 32'(m_valid));
      chk({tag, ".halted"}, 32'(halted),      32'(m_halted_st));
      chk({tag, ".rd"},     32'(imem_rd),     32'(m_running));
      chk({tag, ".addr"},   32'(imem_addr),   32'(m_pc));
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".cnt"},    32'(fetch_count), 32'(m_cnt));
`endif
   endtask

   // Apply inputs, clock one edge, update the model, sample 1ns after the edge
   task automatic step(input bit s, input bit st, input bit b, input logic [6:0] ba);
      start = s; stall = st; branch_en = b; branch_addr = ba;
      @(posedge clk);
      model_edge(s, st, b, int'(ba));
      #1;
      start = 0; stall = 0; branch_en = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk_model("reset");
      rst_n = 1'b1;
   endtask

   task automatic fill_even();
      for (int i = 0; i < 128; i++) mem[i] = 16'((i + 16'h0200) << 1);
   endtask

   typedef struct {
      bit          s, st, b;
      logic [6:0]  ba;
      logic [6:0]  pc;
      logic [15:0] instr;
      bit          valid, halted, rd;
   } vec_t;

   vec_t vecs[8];

   initial begin
      // ---- table: 3-instruction program with a 3-cycle stall ----
      vecs[0] = '{1, 0, 0, 7'd0, 7'd0, 16'h0000, 0, 0, 1};
      vecs[1] = '{0, 0, 0, 7'd0, 7'd1, 16'h9000, 1, 0, 1};
      vecs[2] = '{0, 0, 0, 7'd0, 7'd2, 16'h9202, 1, 0, 1};
      vecs[3] = '{0, 1, 0, 7'd0, 7'd2, 16'h9202, 1, 0, 1};
      vecs[4] = '{0, 1, 0, 7'd0, 7'd2, 16'h9202, 1, 0, 1};
      vecs[5] = '{0, 1, 0, 7'd0, 7'd2, 16'h9202, 1, 0, 1};
      vecs[6] = '{0, 0, 0, 7'd0, 7'd2, 16'h9403, 1, 1, 0};
      vecs[7] = '{0, 0, 0, 7'd0, 7'd2, 16'h9403, 0, 1, 0};

      fill_even();
      mem[0] = 16'h9000; mem[1] = 16'h9202; mem[2] = 16'h9403;
      #3;
      do_reset();
      #10;
      for (int i = 0; i < 8; i++) begin
         step(vecs[i].s, vecs[i].st, vecs[i].b, vecs[i].ba);
         chk($sformatf("vec%0d.pc", i),     32'(pc),          32'(vecs[i].pc));
         chk($sformatf("vec%0d.instr", i),  32'(instr),       32'(vecs[i].instr));
         chk($sformatf("vec%0d.valid", i),  32'(instr_valid), 32'(vecs[i].valid));
         chk($sformatf("vec%0d.halted", i), 32'(halted),      32'(vecs[i].halted));
         chk($sformatf("vec%0d.rd", i),     32'(imem_rd),     32'(vecs[i].rd));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf.count3", 32'(fetch_count), 32'd3);
`endif
      // branch_en ignored in HALT, then restart from HALT
      step(0, 0, 1, 7'd9);
      chk_model("halt_branch");
      step(1, 0, 0, 7'd0);
      chk_model("halt_restart");
      step(0, 0, 0, 7'd0);
      chk("restart.instr", 32'(instr), 32'h9000);

      // ---- branch from pc=9 to 5 ----
      fill_even();
      do_reset();
      step(1, 0, 0, 7'd0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 7'd0);
      chk("br.pc_before", 32'(pc), 32'd9);
      step(0, 0, 1, 7'd5);
      chk("br.bubble_valid", 32'(instr_valid), 32'd0);
      chk("br.bubble_pc", 32'(pc), 32'd5);
      step(0, 1, 0, 7'd0);
      chk("br.stall_valid", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 7'd0);
      chk("br.instr", 32'(instr), 32'(mem[5]));
      chk("br.pc_after", 32'(pc), 32'd6);
      chk_model("br");

      // ---- stop bit at 3 coincident with branch to 0 ----
      fill_even();
      mem[3] = mem[3] | 16'h0001;
      do_reset();
      step(1, 0, 0, 7'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 7'd0);
      step(0, 0, 1, 7'd0);
      chk("stopbr.halted", 32'(halted), 32'd0);
      chk("stopbr.pc", 32'(pc), 32'd0);
      chk("stopbr.valid", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 7'd0);
      chk("stopbr.instr", 32'(instr), 32'(mem[0]));
      chk_model("stopbr");

      // ---- 129 fetches without a stop bit: pc wraps ----
      fill_even();
      do_reset();
      step(1, 0, 0, 7'd0);
      for (int i = 1; i <= 129; i++) begin
         step(0, 0, 0, 7'd0);
         chk_model($sformatf("wrap%0d", i));
         if (i == 128) chk("wrap.pc0", 32'(pc), 32'd0);
      end
      chk("wrap.instr_mem0", 32'(instr), 32'(mem[0]));

      // ---- asynchronous reset at pc=40 ----
      do_reset();
      step(1, 0, 0, 7'd0);
      for (int i = 0; i < 40; i++) step(0, 0, 0, 7'd0);
      chk("arst.pc_before", 32'(pc), 32'd40);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.pc", 32'(pc), 32'd0);
      chk("arst.instr", 32'(instr), 32'd0);
      chk("arst.valid", 32'(instr_valid), 32'd0);
      chk("arst.rd", 32'(imem_rd), 32'd0);
      chk("arst.halted", 32'(halted), 32'd0);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk_model("arst_idle");

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 128; i++) begin
         mem[i] = 16'($urandom);
         mem[i][0] = ($urandom_range(0, 15) == 0);
      end
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), 7'($urandom));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
